// File: rtl/datapath_core.sv
// Datapath for a small 8-bit bus machine: A/B registers, ALU with flags, IR, MAR, PC,
// output register and a 16x8 RAM, all sharing one combinational bus.
module datapath_core (
  input  logic       clk,
  input  logic       clr,
  input  logic       hlt,
  input  logic       mi_bar,
  input  logic       ro_bar,
  input  logic       io_bar,
  input  logic       ii_bar,
  input  logic       ai_bar,
  input  logic       ao_bar,
  input  logic       eo_bar,
  input  logic       bi_bar,
  input  logic       co_bar,
  input  logic       j_bar,
  input  logic       fi_bar,
  input  logic       ri,
  input  logic       su,
  input  logic       oi,
  input  logic       ce,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [3:0] ir_hi,
  output logic       cf,
  output logic       zf,
  output logic [7:0] out_reg,
  output logic       out_strobe,
  output logic [7:0] bus,
  output logic       bus_err
);

  logic [7:0] a, b, ir;
  logic [3:0] mar, pc;
  logic [7:0] ram [16];
  logic [7:0] alu_b;
  logic [8:0] sum;
  logic       ro, io, ao, eo, co;
  logic       ram_we;

  assign ro = ~ro_bar;
  assign io = ~io_bar;
  assign ao = ~ao_bar;
  assign eo = ~eo_bar;
  assign co = ~co_bar;

  // Subtraction is A + ~B + 1, so carry=1 means "no borrow".
  assign alu_b = su ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, alu_b} + {8'd0, su};

  always_comb begin
    bus = 8'h00;
    if (ro)      bus = ram[mar];
    else if (io) bus = {4'h0, ir[3:0]};
    else if (ao) bus = a;
    else if (eo) bus = sum[7:0];
    else if (co) bus = {4'h0, pc};
  end

  assign bus_err = ({2'b00, ro} + {2'b00, io} + {2'b00, ao} + {2'b00, eo} + {2'b00, co}) > 3'd1;

  assign ir_hi  = ir[7:4];
  assign ram_we = ri & ~hlt & ~clr;

  // RAM is never reset; the program-load write comes last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (ram_we)  ram[mar]       <= bus;
    if (prog_we) ram[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a          <= 8'h00;
      b          <= 8'h00;
      ir         <= 8'h00;
      mar        <= 4'h0;
      pc         <= 4'h0;
      out_reg    <= 8'h00;
      cf         <= 1'b0;
      zf         <= 1'b0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= oi & ~hlt;
      if (!hlt) begin
        if (!mi_bar) mar     <= bus[3:0];
        if (!ii_bar) ir      <= bus;
        if (!ai_bar) a       <= bus;
        if (!bi_bar) b       <= bus;
        if (oi)      out_reg <= bus;
        if (!fi_bar) begin
          cf <= sum[8];
          zf <= (sum[7:0] == 8'h00);
        end
        if (!j_bar)  pc <= bus[3:0];
        else if (ce) pc <= pc + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_datapath_core.sv
// Bench for datapath_core: directed scenarios plus random control words, checked
// every cycle against an arithmetic reference model of the machine state.
module tb_datapath_core;

  localparam logic [14:0] K_MI = 15'h0001, K_RO = 15'h0002, K_IO = 15'h0004, K_II = 15'h0008,
                          K_AI = 15'h0010, K_AO = 15'h0020, K_EO = 15'h0040, K_BI = 15'h0080,
                          K_CO = 15'h0100, K_J  = 15'h0200, K_FI = 15'h0400, K_RI = 15'h0800,
                          K_SU = 15'h1000, K_OI = 15'h2000, K_CE = 15'h4000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        hlt = 1'b0;
  logic [14:0] ctl = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'h0;
  logic [7:0]  prog_data = 8'h00;
  logic [3:0]  ir_hi;
  logic        cf, zf, out_strobe, bus_err;
  logic [7:0]  out_reg, bus;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [7:0] m_a, m_b, m_ir, m_out;
  logic [3:0] m_mar, m_pc;
  logic       m_cf, m_zf, m_strobe;
  logic [7:0] m_ram [16];

  always #5 clk = ~clk;

  datapath_core dut (
    .clk(clk), .clr(clr), .hlt(hlt),
    .mi_bar(~ctl[0]), .ro_bar(~ctl[1]), .io_bar(~ctl[2]), .ii_bar(~ctl[3]),
    .ai_bar(~ctl[4]), .ao_bar(~ctl[5]), .eo_bar(~ctl[6]), .bi_bar(~ctl[7]),
    .co_bar(~ctl[8]), .j_bar(~ctl[9]), .fi_bar(~ctl[10]),
    .ri(ctl[11]), .su(ctl[12]), .oi(ctl[13]), .ce(ctl[14]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ir_hi(ir_hi), .cf(cf), .zf(zf), .out_reg(out_reg), .out_strobe(out_strobe),
    .bus(bus), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ALU as plain arithmetic: add, or subtract where carry means a >= b
  function automatic logic [8:0] m_alu();
    int r;
    logic c;
    if (ctl[12]) begin
      r = int'(m_a) - int'(m_b);
      c = (m_a >= m_b);
    end else begin
      r = int'(m_a) + int'(m_b);
      c = (r > 255);
    end
    return {c, 8'(r & 255)};
  endfunction

  function automatic logic [7:0] m_bus();
    logic [8:0] al;
    al = m_alu();
    if (ctl[1])      return m_ram[m_mar];
    else if (ctl[2]) return {4'h0, m_ir[3:0]};
    else if (ctl[5]) return m_a;
    else if (ctl[6]) return al[7:0];
    else if (ctl[8]) return {4'h0, m_pc};
    return 8'h00;
  endfunction

  function automatic logic m_err();
    int n;
    n = int'(ctl[1]) + int'(ctl[2]) + int'(ctl[5]) + int'(ctl[6]) + int'(ctl[8]);
    return n > 1;
  endfunction

  task automatic m_reset();
    m_a = 0; m_b = 0; m_ir = 0; m_out = 0; m_mar = 0; m_pc = 0;
    m_cf = 0; m_zf = 0; m_strobe = 0;
  endtask

  // One clock: drive, check bus before the edge, update model, check registered outputs after.
  task automatic step(input logic [14:0] c, input logic h = 1'b0, input logic pwe = 1'b0,
                      input logic [3:0] pa = 4'h0, input logic [7:0] pd = 8'h00);
    logic [7:0] bv;
    logic [8:0] al;
    ctl = c; hlt = h; prog_we = pwe; prog_addr = pa; prog_data = pd;
    #1;
    bv = m_bus();
    al = m_alu();
    chk("bus", bus, bv);
    chk("bus_err", {7'd0, bus_err}, {7'd0, m_err()});
    @(posedge clk);
    m_strobe = !clr && !h && c[13];
    if (!clr && !h) begin
      if (c[11]) m_ram[m_mar] = bv;
      if (c[0])  m_mar = bv[3:0];
      if (c[3])  m_ir = bv;
      if (c[4])  m_a = bv;
      if (c[7])  m_b = bv;
      if (c[13]) m_out = bv;
      if (c[10]) begin m_cf = al[8]; m_zf = (al[7:0] == 0); end
      if (c[9])       m_pc = bv[3:0];
      else if (c[14]) m_pc = (m_pc == 15) ? 4'd0 : m_pc + 4'd1;
    end
    if (pwe) m_ram[pa] = pd;
    #1;
    chk("out_reg", out_reg, m_out);
    chk("out_strobe", {7'd0, out_strobe}, {7'd0, m_strobe});
    chk("cf", {7'd0, cf}, {7'd0, m_cf});
    chk("zf", {7'd0, zf}, {7'd0, m_zf});
    chk("ir_hi", {4'd0, ir_hi}, {4'd0, m_ir[7:4]});
    ctl = '0; hlt = 0; prog_we = 0;
  endtask

  // Look at the bus between edges without clocking anything.
  task automatic peek(input logic [14:0] c, input string tag, input logic [7:0] exp,
                      input logic exp_err = 1'b0);
    ctl = c;
    #1;
    chk(tag, bus, exp);
    chk({tag, "_err"}, {7'd0, bus_err}, {7'd0, exp_err});
    ctl = '0;
  endtask

  task automatic load(input logic [14:0] k, input logic [7:0] v);
    step(15'h0, 1'b0, 1'b1, m_mar, v);
    step(K_RO | k);
  endtask

  initial begin
    logic [14:0] c;
    m_reset();
    // RAM load while clr is held
    for (int i = 0; i < 16; i++) step(15'h0, 1'b0, 1'b1, 4'(i), 8'($urandom_range(0, 255)));
    peek(K_CO, "pc_rst", 8'h00);
    peek(K_AO, "a_rst", 8'h00);
    chk("cf_rst", {7'd0, cf}, 8'h00);
    chk("out_rst", out_reg, 8'h00);
    clr = 0;

    // fetch
    clr = 1; #1; m_reset(); clr = 0;
    step(15'h0, 1'b0, 1'b1, 4'h0, 8'h1E);
    step(K_CO | K_MI);
    step(K_RO | K_II | K_CE);
    chk("fetch_ir_hi", {4'd0, ir_hi}, 8'h01);
    peek(K_IO, "fetch_ir_lo", 8'h0E);
    peek(K_CO, "fetch_pc", 8'h01);
    peek(K_RO, "fetch_mar0", 8'h1E);

    // add with flags
    load(K_AI, 8'hF0); load(K_BI, 8'h10);
    step(K_EO | K_AI | K_FI);
    chk("add_cf", {7'd0, cf}, 8'h01);
    chk("add_zf", {7'd0, zf}, 8'h01);
    peek(K_AO, "add_a", 8'h00);

    // subtract equal
    load(K_AI, 8'h05); load(K_BI, 8'h05);
    step(K_EO | K_FI | K_SU);
    chk("sub_eq_cf", {7'd0, cf}, 8'h01);
    chk("sub_eq_zf", {7'd0, zf}, 8'h01);
    peek(K_AO, "sub_eq_a", 8'h05);

    // subtract with borrow
    load(K_AI, 8'h03);
    peek(K_EO | K_SU, "sub_res", 8'hFE);
    step(K_EO | K_FI | K_SU);
    chk("sub_lt_cf", {7'd0, cf}, 8'h00);
    chk("sub_lt_zf", {7'd0, zf}, 8'h00);
    step(K_EO);
    chk("flags_hold", {6'd0, cf, zf}, 8'h00);

    // PC wrap and jump-over-increment
    load(K_J, 8'h0F);
    peek(K_CO, "pc15", 8'h0F);
    step(K_CE);
    peek(K_CO, "pc_wrap", 8'h00);
    load(K_J, 8'h0F);
    step(15'h0, 1'b0, 1'b1, m_mar, 8'h07);
    step(K_RO | K_J | K_CE);
    peek(K_CO, "pc_jump", 8'h07);

    // output strobe and bus conflict
    load(K_AI, 8'h2A);
    step(K_AO | K_OI);
    chk("out_val", out_reg, 8'h2A);
    chk("strobe_hi", {7'd0, out_strobe}, 8'h01);
    step(15'h0);
    chk("strobe_lo", {7'd0, out_strobe}, 8'h00);
    peek(K_AO | K_CO, "conflict", 8'h2A, 1'b1);

    // halt, program load under halt, async clear
    step(15'h0, 1'b0, 1'b1, m_mar, 8'h55);
    step(K_RO | K_AI, 1'b1, 1'b1, 4'h3, 8'h77);
    peek(K_AO, "halt_a", 8'h2A);
    clr = 1; #1; m_reset();
    peek(K_AO, "clr_a", 8'h00);
    peek(K_CO, "clr_pc", 8'h00);
    step(K_RO | K_AI | K_CE);
    clr = 0;
    peek(K_AO, "clr_discard", 8'h00);
    step(15'h0, 1'b0, 1'b1, 4'h0, 8'h03);
    step(K_RO | K_MI);
    peek(K_RO, "ram3_kept", 8'h77);

    // ri and prog_we collide on the same address: program load wins
    step(K_AO | K_RI, 1'b0, 1'b1, m_mar, 8'hC3);
    peek(K_RO, "prog_wins", 8'hC3);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if (n % 97 == 96) begin
        clr = 1; #1; m_reset();
        peek(K_CO, "rand_clr_pc", 8'h00);
        clr = 0;
      end
      c = '0;
      for (int i = 0; i < 15; i++) c[i] = ($urandom_range(0, 3) == 0);
      step(c, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/datapath_core.md
DATAPATH_CORE -- requirements
Module: datapath_core

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 clr  in  1  asynchronous, active-high reset.
REQ-003 hlt  in  1  halt; when 1, suppresses every CPU-side register and RAM update.
REQ-004 mi_bar, ro_bar, io_bar, ii_bar, ai_bar, ao_bar, eo_bar, bi_bar, co_bar, j_bar, fi_bar  in  1 each  active-low control lines from the control unit.
REQ-005 ri, su, oi, ce  in  1 each  active-high control lines from the control unit.
REQ-006 prog_we  in  1  program-load write strobe.
REQ-007 prog_addr  in  4  program-load address.
REQ-008 prog_data  in  8  program-load data.
REQ-009 ir_hi  out  4  IR[7:4], the opcode; bits 3..0 drive the control unit's ir_7..ir_4 inputs.
REQ-010 cf, zf  out  1 each  registered carry and zero flags.
REQ-011 out_reg  out  8  output register.
REQ-012 out_strobe  out  1  one-cycle pulse marking an out_reg update.
REQ-013 bus  out  8  current internal bus value, for debug.
REQ-014 bus_err  out  1  combinational; 1 when more than one bus driver is enabled.

Function
REQ-015 The block SHALL hold these state elements:
- A, B, IR, out_reg: 8 bits each.
- MAR, PC: 4 bits each.
- cf, zf: 1 bit each.
- RAM: 16x8.
REQ-016 The bus SHALL be combinational, driven by one of the following sources, with priority ro > io > ao > eo > co:
- ro: RAM[MAR].
- io: {4'h0, IR[3:0]}.
- ao: A.
- eo: ALU result.
- co: {4'h0, PC}.
REQ-017 When no source is enabled, the bus SHALL read 8'h00 and bus_err SHALL be 0.
REQ-018 ALU SHALL form the 9-bit sum {0,A} + {0,(su ? ~B : B)} + su; result = sum[7:0], carry = sum[8].
REQ-019 The ALU SHALL be combinational from the current A, B and su.
REQ-020 On a rising edge with hlt=0, the block SHALL perform all of these loads in the same cycle:
- mi: MAR <= bus[3:0].
- ri: RAM[MAR] <= bus.
- ii: IR <= bus.
- ai: A <= bus.
- bi: B <= bus.
- oi: out_reg <= bus.
- fi: cf <= carry, zf <= (result == 8'h00).
REQ-021 Every load in REQ-020 SHALL sample pre-edge values (bus, MAR, A, B), so ai together with eo loads the old A+B.
REQ-022 PC update: j=1 SHALL load PC <= bus[3:0]; otherwise ce=1 SHALL increment PC modulo 16 (15 -> 0); j SHALL override ce.
REQ-023 out_strobe SHALL be 1 for exactly the cycle following each edge on which out_reg was loaded.
REQ-024 While hlt=1, all registers, flags and RAM SHALL hold, except for the program-load path.
REQ-025 prog_we=1 SHALL write RAM[prog_addr] <= prog_data on the rising edge, regardless of hlt.
REQ-026 If prog_we and ri write in the same cycle, the prog_we write SHALL win, whether or not the addresses match; a ri write to a different address SHALL also complete.
REQ-027 RAM reads SHALL be asynchronous; a write SHALL become visible on the bus the cycle after the edge.
REQ-028 The flags SHALL change only on fi; ALU activity without fi SHALL leave cf/zf unchanged.

Reset
REQ-029 clr=1 SHALL immediately (asynchronously) clear A, B, IR, MAR, PC, out_reg, cf, zf and out_strobe to 0, independent of clk.
REQ-030 RAM contents SHALL NOT be reset.
REQ-031 While clr=1, the prog_we path SHALL remain functional.
REQ-032 When clr is asserted mid-operation, all pending loads for that edge SHALL be discarded.
REQ-033 The first update after clr deasserts SHALL occur on the next rising clk.

Verification
REQ-034 Load/fetch: clr pulse, then prog_we RAM[0]=8'h1E, then co+mi, then ro+ii+ce -> MAR=0, IR=8'h1E, ir_hi=4'h1, PC=1.
REQ-035 Add with flags: A=8'hF0, B=8'h10, su=0, eo+ai+fi -> A=8'h00, cf=1, zf=1.
REQ-036 Subtract: A=8'h05, B=8'h05, su=1, eo+fi -> cf=1, zf=1, A unchanged.
REQ-037 Subtract: A=8'h03, B=8'h05, su=1, eo+fi -> result 8'hFE, cf=0, zf=0.
REQ-038 PC wrap: PC=15 with ce -> PC=0; same cycle j with bus=8'h07 -> PC=7.
REQ-039 Output and bus conflict: A=8'h2A, ao+oi -> out_reg=8'h2A and one-cycle out_strobe; then ao+co both active -> bus=A, bus_err=1.
REQ-040 Halt and async reset:
- hlt=1 with ai, bus=8'h55 -> A unchanged.
- Same cycle prog_we RAM[3]=8'h77 -> written.
- clr asserted between edges -> A=PC=0 immediately; RAM[3] still 8'h77.
